load_store_unit: RTL and testbench

- Core-side initiator for the data-memory interface.
- Accepts one load/store at a time from the execute stage.
- Translates it into word-aligned, byte-enabled bus transactions.
- Splits misaligned accesses that cross a word boundary into two beats.
- Merges and sign/zero-extends read data, then returns one response to the core.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and
// the byte-mask helper used by the lane-alignment logic.
package riscv_pkg;

    localparam int LSU_BE_W = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ0  = 3'd1,
        LSU_WAIT0 = 3'd2,
        LSU_REQ1  = 3'd3,
        LSU_WAIT1 = 3'd4,
        LSU_RESP  = 3'd5
    } lsu_state_t;

    // Right-aligned byte mask for an access size; the illegal encoding gets
    // an empty mask so it can never enable a lane.
    function automatic logic [LSU_BE_W-1:0] size_mask(input logic [1:0] size);
        logic [LSU_BE_W-1:0] mask;
        case (size)
            MEM_BYTE: mask = 4'b0001;
            MEM_HALF: mask = 4'b0011;
            MEM_WORD: mask = 4'b1111;
            default:  mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit: byte enables and write-data
// lanes for both beats, plus read merge, truncation and sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]          off,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [31:0]         wdata,
    input  logic [31:0]         rdata0,
    input  logic [31:0]         rdata1,
    output logic                split,
    output logic [LSU_BE_W-1:0] be0,
    output logic [LSU_BE_W-1:0] be1,
    output logic [31:0]         wdata0,
    output logic [31:0]         wdata1,
    output logic [31:0]         load_data
);

    logic [7:0]  m8;
    logic [63:0] wide;
    logic [31:0] merged;
    logic [4:0]  shamt;

    // Lane placement: the two-word window {beat1, beat0} viewed little-endian.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        load_data = '0;
        shamt     = {off, 3'b000};
        m8        = {4'b0000, size_mask(size)} << off;
        be0       = m8[3:0];
        be1       = m8[7:4];
        split     = (m8[7:4] != 4'b0000);
        wide      = {32'h0, wdata} << shamt;
        wdata0    = wide[31:0];
        wdata1    = wide[63:32];
        merged    = 32'({rdata1, rdata0} >> shamt);
        case (size)
            MEM_BYTE: load_data = sign_ext ? {{24{merged[7]}}, merged[7:0]}
                                           : {24'h0, merged[7:0]};
            MEM_HALF: load_data = sign_ext ? {{16{merged[15]}}, merged[15:0]}
                                           : {16'h0, merged[15:0]};
            MEM_WORD: load_data = merged;
            default:  load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-side data-memory initiator: accepts one load/store, issues one or two
// word-aligned byte-enabled bus beats, and returns a single response.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [XLEN-1:0]     req_addr_i,
    input  logic [XLEN-1:0]     req_wdata_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_sign_ext_i,
    output logic                rsp_valid_o,
    output logic [XLEN-1:0]     rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                bus_req_o,
    input  logic                bus_gnt_i,
    output logic                bus_we_o,
    output logic [XLEN-1:0]     bus_addr_o,
    output logic [LSU_BE_W-1:0] bus_be_o,
    output logic [XLEN-1:0]     bus_wdata_o,
    input  logic                bus_rvalid_i,
    input  logic [XLEN-1:0]     bus_rdata_i
);

    lsu_state_t      state_q, state_d;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      size_q;
    logic            sign_q;
    logic [XLEN-1:0] rdata0_q;
    logic [XLEN-1:0] rdata1_q;

    logic                split;
    logic [LSU_BE_W-1:0] be0, be1;
    logic [XLEN-1:0]     wdata0, wdata1, load_data;
    logic [XLEN-1:0]     word_addr;
    logic                err;
    logic                accept;

    assign word_addr = {addr_q[XLEN-1:2], 2'b00};
    assign err       = (size_q == 2'b11);
    assign accept    = (state_q == LSU_IDLE) && req_valid_i;

    lsu_align u_align (
        .off       (addr_q[1:0]),
        .size      (size_q),
        .sign_ext  (sign_q),
        .wdata     (wdata_q),
        .rdata0    (rdata0_q),
        .rdata1    (rdata1_q),
        .split     (split),
        .be0       (be0),
        .be1       (be1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .load_data (load_data)
    );

    // State register, request capture and per-beat read-data capture.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            // NOTE: data registers are cleared too, so nothing from an abandoned access survives a reset.
            state_q  <= LSU_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                size_q   <= req_size_i;
                sign_q   <= req_sign_ext_i;
                rdata0_q <= '0;
                rdata1_q <= '0;
            end
            if (state_q == LSU_WAIT0 && bus_rvalid_i) begin
                rdata0_q <= bus_rdata_i;
            end
            if (state_q == LSU_WAIT1 && bus_rvalid_i) begin
                rdata1_q <= bus_rdata_i;
            end
        end
    end

    // Next-state and output decode; reset forces every output to zero.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_be_o    = '0;
        bus_wdata_o = '0;

        case (state_q)
            LSU_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = (req_size_i == 2'b11) ? LSU_RESP : LSU_REQ0;
                end
            end
            LSU_REQ0: begin
                bus_req_o   = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = word_addr;
                bus_be_o    = be0;
                bus_wdata_o = wdata0;
                if (bus_gnt_i) state_d = LSU_WAIT0;
            end
            LSU_WAIT0: begin
                if (bus_rvalid_i) state_d = split ? LSU_REQ1 : LSU_RESP;
            end
            LSU_REQ1: begin
                bus_req_o   = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = word_addr + XLEN'(4);
                bus_be_o    = be1;
                bus_wdata_o = wdata1;
                if (bus_gnt_i) state_d = LSU_WAIT1;
            end
            LSU_WAIT1: begin
                if (bus_rvalid_i) state_d = LSU_RESP;
            end
            LSU_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err;
                rsp_rdata_o = (we_q || err) ? '0 : load_data;
                state_d     = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase

        if (rst_i) begin
            state_d     = LSU_IDLE;
            req_ready_o = 1'b0;
            rsp_valid_o = 1'b0;
            rsp_rdata_o = '0;
            rsp_err_o   = 1'b0;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_be_o    = '0;
            bus_wdata_o = '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// loads/stores against a byte-addressed reference memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign_ext = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;

    // Bus-side memory (words) and the reference model's memory (bytes).
    logic [31:0] slave_mem [bit [31:0]];
    logic [7:0]  ref_mem   [bit [31:0]];

    // Results of the most recent access, visible to directed checks.
    logic [31:0] g_addr [2];
    logic [3:0]  g_be   [2];
    logic [31:0] g_wd   [2];
    int          g_n;
    int          g_lat;
    logic [31:0] g_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_size_i     (req_size),
        .req_sign_ext_i (req_sign_ext),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .bus_req_o      (bus_req),
        .bus_gnt_i      (bus_gnt),
        .bus_we_o       (bus_we),
        .bus_addr_o     (bus_addr),
        .bus_be_o       (bus_be),
        .bus_wdata_o    (bus_wdata),
        .bus_rvalid_i   (bus_rvalid),
        .bus_rdata_i    (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] w);
        return (w * 32'h9E37_79B1) ^ 32'h5A17_C3E1;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] w);
        if (slave_mem.exists(w)) return slave_mem[w];
        return init_word(w);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word({a[31:2], 2'b00});
        return w[a[1:0]*8 +: 8];
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // One complete access: model expectations, request handshake, bus slave
    // with random (or forced zero-wait) grant/rvalid timing, then checks.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic sign, input int hold_force);
        logic [31:0] e_addr [2];
        logic [3:0]  e_be   [2];
        logic [31:0] e_wd   [2];
        int          e_n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] a, w, first_w, v;
        int          nbytes, b;
        bit          done, outstanding, in_beat;
        int          hold, rvd, cyc;
        logic [31:0] gaddr, s_addr, s_wd, m;
        logic [3:0]  s_be;
        logic        s_we, got_err;

        // Reference model: byte-by-byte little-endian view of the access.
        exp_err = (size == 2'b11);
        e_n = 0;
        for (int i = 0; i < 2; i++) begin
            e_addr[i] = '0; e_be[i] = '0; e_wd[i] = '0;
        end
        v = '0;
        if (!exp_err) begin
            nbytes  = 1 << size;
            first_w = addr & 32'hFFFF_FFFC;
            for (int i = 0; i < nbytes; i++) begin
                a = addr + 32'(i);
                w = a & 32'hFFFF_FFFC;
                b = (w == first_w) ? 0 : 1;
                e_addr[b] = w;
                e_be[b][a[1:0]] = 1'b1;
                e_wd[b][a[1:0]*8 +: 8] = wdata[i*8 +: 8];
                if (b + 1 > e_n) e_n = b + 1;
                v[i*8 +: 8] = ref_rd(a);
                if (we) ref_mem[a] = wdata[i*8 +: 8];
            end
            if (sign && nbytes == 1) v = {{24{v[7]}}, v[7:0]};
            if (sign && nbytes == 2) v = {{16{v[15]}}, v[15:0]};
        end
        exp_rdata = (we || exp_err) ? 32'h0 : v;

        @(negedge clk);
        check("ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_size = size; req_sign_ext = sign;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom;

        done = 0; outstanding = 0; in_beat = 0; hold = 0; rvd = 0; cyc = 0;
        g_n = 0; got_err = 1'b0; g_rdata = '0; gaddr = '0;
        s_addr = '0; s_wd = '0; s_be = '0; s_we = 1'b0;
        while (!done && cyc < 200) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            if (rsp_valid) begin
                done = 1; g_rdata = rsp_rdata; got_err = rsp_err; g_lat = cyc + 2;
            end else begin
                if (outstanding) begin
                    if (rvd == 0) begin
                        bus_rvalid = 1'b1; bus_rdata = slave_rd(gaddr); outstanding = 0;
                    end else begin
                        rvd--;
                    end
                end else if (bus_req) begin
                    check("busy_not_ready", {31'h0, req_ready}, 32'h0);
                    if (!in_beat) begin
                        in_beat = 1;
                        s_addr = bus_addr; s_be = bus_be; s_wd = bus_wdata; s_we = bus_we;
                        if (g_n < 2) begin
                            g_addr[g_n] = bus_addr; g_be[g_n] = bus_be; g_wd[g_n] = bus_wdata;
                            check("beat_we", {31'h0, bus_we}, {31'h0, we});
                        end
                        g_n++;
                        hold = (hold_force >= 0) ? hold_force : int'($urandom_range(2));
                    end else begin
                        check("hold_addr", bus_addr, s_addr);
                        check("hold_be", {28'h0, bus_be}, {28'h0, s_be});
                        check("hold_wdata", bus_wdata, s_wd);
                        check("hold_we", {31'h0, bus_we}, {31'h0, s_we});
                    end
                    if (hold == 0) begin
                        bus_gnt = 1'b1; in_beat = 0; outstanding = 1; gaddr = s_addr;
                        rvd = (hold_force >= 0) ? 0 : int'($urandom_range(2));
                        if (s_we) begin
                            m = lane_mask(s_be);
                            slave_mem[s_addr] = (slave_rd(s_addr) & ~m) | (s_wd & m);
                        end
                    end else begin
                        hold--;
                    end
                end
                // Stray completions outside WAIT states must be ignored.
                if (hold_force < 0 && !outstanding && !bus_gnt && !bus_rvalid && $urandom_range(5) == 0)
                    bus_rvalid = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (!done) begin
            check("rsp_timeout", 32'h0, 32'h1);
        end else begin
            check("rsp_err", {31'h0, got_err}, {31'h0, exp_err});
            check("rsp_rdata", g_rdata, exp_rdata);
            check("beat_count", 32'(g_n), 32'(e_n));
            for (int i = 0; i < 2; i++) begin
                if (i < e_n && i < g_n) begin
                    check("beat_addr", g_addr[i], e_addr[i]);
                    check("beat_be", {28'h0, g_be[i]}, {28'h0, e_be[i]});
                    if (we) check("beat_wdata", g_wd[i] & lane_mask(e_be[i]), e_wd[i]);
                end
            end
            @(negedge clk);
            check("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        logic [1:0]  size;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", {28'h0, bus_be}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst_i = 1'b0;

        // Aligned word store, zero-wait bus.
        do_access(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 2'b10, 1'b0, 0);
        check("sw_be", {28'h0, g_be[0]}, 32'hF);
        check("sw_wdata", g_wd[0], 32'hDEAD_BEEF);
        check("lat_single", 32'(g_lat), 32'd4);

        // Sub-word loads with and without sign extension.
        do_access(1'b1, 32'h1000_0000, 32'h8899_AABB, 2'b10, 1'b0, -1);
        do_access(1'b0, 32'h1000_0001, 32'h0, 2'b01, 1'b0, -1);
        check("lhu_be", {28'h0, g_be[0]}, 32'h6);
        check("lhu_data", g_rdata, 32'h0000_99AA);
        do_access(1'b0, 32'h1000_0001, 32'h0, 2'b01, 1'b1, -1);
        check("lh_data", g_rdata, 32'hFFFF_99AA);
        do_access(1'b0, 32'h1000_0003, 32'h0, 2'b00, 1'b1, -1);
        check("lb_data", g_rdata, 32'hFFFF_FF88);

        // Split word load, zero-wait bus.
        do_access(1'b1, 32'h1000_0000, 32'h4433_2211, 2'b10, 1'b0, -1);
        do_access(1'b1, 32'h1000_0004, 32'h8877_6655, 2'b10, 1'b0, -1);
        do_access(1'b0, 32'h1000_0003, 32'h0, 2'b10, 1'b0, 0);
        check("slw_be0", {28'h0, g_be[0]}, 32'h8);
        check("slw_be1", {28'h0, g_be[1]}, 32'h7);
        check("slw_data", g_rdata, 32'h7766_5544);
        check("lat_split", 32'(g_lat), 32'd6);

        // Split halfword store.
        do_access(1'b1, 32'h1000_0007, 32'h0000_ABCD, 2'b01, 1'b0, -1);
        check("ssh_addr0", g_addr[0], 32'h1000_0004);
        check("ssh_wd0", g_wd[0], 32'hCD00_0000);
        check("ssh_addr1", g_addr[1], 32'h1000_0008);
        check("ssh_wd1", g_wd[1], 32'h0000_00AB);

        // Grant held low for three cycles.
        do_access(1'b1, 32'h1000_0010, 32'h1234_5678, 2'b10, 1'b0, 3);

        // Illegal size and address wrap.
        do_access(1'b0, 32'h1000_0000, 32'h0, 2'b11, 1'b0, -1);
        do_access(1'b0, 32'hFFFF_FFFE, 32'h0, 2'b10, 1'b1, -1);
        check("wrap_addr1", g_addr[1], 32'h0000_0000);
        check("wrap_be1", {28'h0, g_be[1]}, 32'h3);

        // Reset during WAIT1 of a split load abandons the access.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000_0003; req_size = 2'b10;
        @(negedge clk);
        req_valid = 1'b0; bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
        @(negedge clk);
        bus_rvalid = 1'b0;
        check("rst_mid_req1", {31'h0, bus_req}, 32'h1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; rst_i = 1'b1;
        @(negedge clk);
        check("rst_mid_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_mid_rsp", {31'h0, rsp_valid}, 32'h0);
        check("rst_mid_ready", {31'h0, req_ready}, 32'h0);
        rst_i = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            check("stray_no_rsp", {31'h0, rsp_valid}, 32'h0);
            check("stray_no_req", {31'h0, bus_req}, 32'h0);
        end
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // Random traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(7) == 0) addr = 32'hFFFF_FFF8 + 32'($urandom_range(7));
            else                        addr = 32'h1000_0000 + 32'($urandom_range(63));
            size = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
            do_access(1'($urandom_range(1)), addr, $urandom, size, 1'($urandom_range(1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
